// File: rtl/word_round_ctrl_if.sv
// rtl/word_round_ctrl_if.sv - game-flow bus between word_round_ctrl, word ROM and PlayerActivity
interface word_round_ctrl_if;
    logic        start;
    logic        word_done;
    logic [19:0] rom_data;
    logic [3:0]  rom_addr;
    logic [19:0] current_word;
    logic [19:0] next_word;
    logic        load_word;
    logic        swstart;
    logic [3:0]  timer_sec;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [1:0]  level;
    logic [2:0]  state;
    logic        game_over;

    modport master (
        output start, word_done, rom_data,
        input  rom_addr, current_word, next_word, load_word, swstart,
        input  timer_sec, score, lives, level, state, game_over
    );

    modport slave (
        input  start, word_done, rom_data,
        output rom_addr, current_word, next_word, load_word, swstart,
        output timer_sec, score, lives, level, state, game_over
    );
endinterface

// File: rtl/word_round_ctrl.sv
// rtl/word_round_ctrl.sv - typing-game sequencer: word fetch, countdown, score, lives, level
module word_round_ctrl #(
    parameter int NUM_WORDS     = 16,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int WORD_TIME_SEC = 10,
    parameter int START_LIVES   = 3
) (
    input  logic               clk,
    input  logic               reset,
    word_round_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_CUR  = 3'd1,
        ST_FETCH_NEXT = 3'd2,
        ST_PLAY       = 3'd3,
        ST_ADVANCE    = 3'd4,
        ST_OVER       = 3'd5
    } state_t;

    localparam int                TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        ADDR_LAST = 4'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [3:0]          rom_addr_q, rom_addr_d;
    logic [19:0]         cur_q, cur_d;
    logic [19:0]         nxt_q, nxt_d;
    logic                load_q, load_d;
    logic [3:0]          timer_q, timer_d;
    logic [7:0]          score_q, score_d;
    logic [1:0]          lives_q, lives_d;
    logic [1:0]          level_q, level_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [7:0]          done_q, done_d;

    logic [3:0]          addr_inc;
    logic [8:0]          score_sum;
    logic [7:0]          done_inc;
    logic [1:0]          level_new;
    logic [3:0]          reload;
    logic                tick_wrap;

    assign addr_inc  = (rom_addr_q == ADDR_LAST) ? 4'd0 : rom_addr_q + 4'd1;
    assign score_sum = {1'b0, score_q} + 9'd1 + {7'd0, level_q};
    assign done_inc  = (done_q == 8'hFF) ? 8'hFF : done_q + 8'd1;
    assign level_new = (done_inc >= 8'd24) ? 2'd3 : done_inc[4:3];
    // Reload always uses level_q: ADVANCE runs one cycle after the level update.
    assign reload    = 4'(WORD_TIME_SEC) - {2'b00, level_q};
    assign tick_wrap = (tick_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        load_d     = 1'b0;
        timer_d    = timer_q;
        score_d    = score_q;
        lives_d    = lives_q;
        level_d    = level_q;
        tick_d     = tick_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    rom_addr_d = 4'd0;
                    score_d    = 8'd0;
                    level_d    = 2'd0;
                    lives_d    = 2'(START_LIVES);
                    done_d     = 8'd0;
                    state_d    = ST_FETCH_CUR;
                end
            end
            ST_FETCH_CUR: begin
                cur_d      = bus.rom_data;
                rom_addr_d = addr_inc;
                state_d    = ST_FETCH_NEXT;
            end
            ST_FETCH_NEXT: begin
                nxt_d      = bus.rom_data;
                rom_addr_d = addr_inc;
                timer_d    = reload;
                tick_d     = '0;
                load_d     = 1'b1;
                state_d    = ST_PLAY;
            end
            ST_PLAY: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap) begin
                    timer_d = timer_q - 4'd1;
                end
                // A completed word beats a simultaneous timeout.
                if (bus.word_done) begin
                    score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    done_d  = done_inc;
                    level_d = level_new;
                    state_d = ST_ADVANCE;
                end else if (tick_wrap && timer_q == 4'd1) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? ST_OVER : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                cur_d      = nxt_q;
                nxt_d      = bus.rom_data;
                rom_addr_d = addr_inc;
                timer_d    = reload;
                tick_d     = '0;
                load_d     = 1'b1;
                state_d    = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= 4'd0;
            cur_q      <= 20'd0;
            nxt_q      <= 20'd0;
            load_q     <= 1'b0;
            timer_q    <= 4'd0;
            score_q    <= 8'd0;
            lives_q    <= 2'd0;
            level_q    <= 2'd0;
            tick_q     <= '0;
            done_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            load_q     <= load_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.current_word = cur_q;
    assign bus.next_word    = nxt_q;
    assign bus.load_word    = load_q;
    assign bus.swstart      = load_q;
    assign bus.timer_sec    = timer_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.state        = state_q;
    assign bus.game_over    = (state_q == ST_OVER);
endmodule

// File: tb/tb_word_round_ctrl.sv
// tb/tb_word_round_ctrl.sv - directed scoreboard bench for word_round_ctrl
module tb_word_round_ctrl;
    localparam int TPS = 4;
    localparam int WTS = 4;
    localparam int NW  = 16;
    localparam int SL  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    word_round_ctrl_if bus ();

    word_round_ctrl #(
        .NUM_WORDS    (NW),
        .TICKS_PER_SEC(TPS),
        .WORD_TIME_SEC(WTS),
        .START_LIVES  (SL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // ROM[i] = i * 0x1111, read off the registered address
    assign bus.rom_data = 20'(bus.rom_addr) * 20'h01111;

    typedef struct {
        logic [19:0] cur;
        logic [19:0] nxt;
        logic [3:0]  tmr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_addr, m_score, m_lives, m_level, m_done;
    logic [19:0] m_cur, m_nxt;

    function automatic logic [19:0] rv(input int i);
        return 20'(i * 32'h1111);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_next();
        exp_t e;
        e.cur = m_nxt;
        e.nxt = rv(m_addr);
        e.tmr = 4'(WTS - m_level);
        sb.push_back(e);
        m_nxt  = rv(m_addr);
        m_addr = (m_addr + 1) % NW;
    endtask

    task automatic pop_load(input string tag);
        exp_t e;
        chk({tag, "_load"}, 32'(bus.load_word), 32'd1);
        chk({tag, "_sw"}, 32'(bus.swstart), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            m_cur = e.cur;
            chk({tag, "_cur"}, 32'(bus.current_word), 32'(e.cur));
            chk({tag, "_nxt"}, 32'(bus.next_word), 32'(e.nxt));
            chk({tag, "_tmr"}, 32'(bus.timer_sec), 32'(e.tmr));
        end
    endtask

    task automatic do_start(input string tag);
        exp_t e;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        m_score = 0; m_level = 0; m_lives = SL; m_done = 0;
        chk({tag, "_st1"}, 32'(bus.state), 32'd1);
        cyc(1);
        chk({tag, "_st2"}, 32'(bus.state), 32'd2);
        cyc(1);
        e.cur = rv(0); e.nxt = rv(1); e.tmr = 4'(WTS);
        sb.push_back(e);
        m_nxt = rv(1); m_addr = 2;
        chk({tag, "_st3"}, 32'(bus.state), 32'd3);
        pop_load(tag);
        chk({tag, "_lives"}, 32'(bus.lives), 32'(SL));
        chk({tag, "_score"}, 32'(bus.score), 32'd0);
    endtask

    task automatic advance_done(input string tag, input int delay);
        if (delay > 0) begin
            cyc(delay);
            chk({tag, "_tmr1"}, 32'(bus.timer_sec), 32'(WTS - m_level - ((delay) / TPS)));
        end
        bus.word_done = 1'b1;
        cyc(1);
        bus.word_done = 1'b0;
        m_score = (m_score + 1 + m_level > 255) ? 255 : m_score + 1 + m_level;
        m_done++;
        m_level = (m_done / 8 > 3) ? 3 : m_done / 8;
        push_next();
        chk({tag, "_adv"}, 32'(bus.state), 32'd4);
        chk({tag, "_gap"}, 32'(bus.load_word), 32'd0);
        chk({tag, "_score"}, 32'(bus.score), 32'(m_score));
        chk({tag, "_lives"}, 32'(bus.lives), 32'(m_lives));
        cyc(1);
        pop_load(tag);
        chk({tag, "_play"}, 32'(bus.state), 32'd3);
        chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(m_addr));
        chk({tag, "_lvl"}, 32'(bus.level), 32'(m_level));
    endtask

    task automatic timeout(input string tag);
        int n;
        n = TPS * (WTS - m_level);
        cyc(n - 1);
        chk({tag, "_pre"}, 32'(bus.state), 32'd3);
        chk({tag, "_tmr1"}, 32'(bus.timer_sec), 32'd1);
        cyc(1);
        m_lives--;
        chk({tag, "_lives"}, 32'(bus.lives), 32'(m_lives));
        if (m_lives == 0) begin
            chk({tag, "_over"}, 32'(bus.state), 32'd5);
            chk({tag, "_go"}, 32'(bus.game_over), 32'd1);
        end else begin
            chk({tag, "_adv"}, 32'(bus.state), 32'd4);
            push_next();
            cyc(1);
            pop_load(tag);
            chk({tag, "_score"}, 32'(bus.score), 32'(m_score));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.word_done = 1'b0;
        cyc(2);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_lives", 32'(bus.lives), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_load", 32'(bus.load_word), 32'd0);
        chk("rst_go", 32'(bus.game_over), 32'd0);
        reset = 1'b0;
        cyc(1);
        chk("idle_hold", 32'(bus.state), 32'd0);

        do_start("startA");
        advance_done("wd1", 0);
        chk("wd1_score1", 32'(bus.score), 32'd1);
        advance_done("wd_on_tmo", TPS * WTS - 1);
        chk("tmo_lives_kept", 32'(bus.lives), 32'd3);
        timeout("tmo1");
        timeout("tmo2");
        timeout("tmo3");

        bus.word_done = 1'b1;
        cyc(1);
        bus.word_done = 1'b0;
        cyc(1);
        chk("over_score", 32'(bus.score), 32'(m_score));
        chk("over_cur", 32'(bus.current_word), 32'(m_cur));
        chk("over_state", 32'(bus.state), 32'd5);

        do_start("startB");
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("start_in_play", 32'(bus.state), 32'd3);
        for (int i = 0; i < 8; i++) advance_done("lvl0", 0);
        chk("lvl1", 32'(bus.level), 32'd1);
        chk("lvl1_tmr", 32'(bus.timer_sec), 32'd3);
        advance_done("lvl1_wd", 0);
        chk("lvl1_score", 32'(bus.score), 32'd10);
        for (int i = 0; i < 71; i++) advance_done("sat", 0);
        chk("sat_score", 32'(bus.score), 32'd255);
        chk("sat_lvl", 32'(bus.level), 32'd3);

        reset = 1'b1;
        bus.start = 1'b1;
        bus.word_done = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.word_done = 1'b0;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_score", 32'(bus.score), 32'd0);
        chk("mid_rst_lives", 32'(bus.lives), 32'd0);
        chk("mid_rst_lvl", 32'(bus.level), 32'd0);
        chk("mid_rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("mid_rst_cur", 32'(bus.current_word), 32'd0);
        chk("mid_rst_nxt", 32'(bus.next_word), 32'd0);
        chk("mid_rst_tmr", 32'(bus.timer_sec), 32'd0);
        chk("mid_rst_load", 32'(bus.load_word), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
